// File: rtl/bullet_ctrl.sv
// Two-slot player bullet controller: fire edge capture, per-frame motion,
// hit retirement, cooldown gating and per-pixel bullet coverage.
module bullet_ctrl #(
  parameter int BULLET_W = 2,
  parameter int BULLET_H = 6,
  parameter int SPEED    = 4,
  parameter int COOLDOWN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       move,
  input  logic       shoot,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic [1:0] hit,
  output logic [1:0] draw_bullets,
  output logic [1:0] bullet_active,
  output logic [7:0] shots_fired
);

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  logic            r_shoot_d;
  logic            r_fire_req;
  logic [CD_W-1:0] r_cooldown;
  logic [7:0]      r_shots;
  logic            r_active   [2];
  logic            r_hit_pend [2];
  logic            r_draw     [2];
  logic [9:0]      r_x        [2];
  logic [9:0]      r_y        [2];

  logic            w_edge;
  logic            w_fire;
  logic            w_spawn;
  logic [1:0]      w_spawn_sel;

  // An edge arriving on the move clock itself still counts for that move.
  assign w_edge  = shoot & ~r_shoot_d;
  assign w_fire  = r_fire_req | w_edge;
  assign w_spawn = move & w_fire & (r_cooldown == '0)
                 & (ship_y >= 10'(BULLET_H))
                 & ~(r_active[0] & r_active[1]);

  // Slot choice uses pre-move occupancy so a slot retiring now is not reused.
  assign w_spawn_sel[0] = w_spawn & ~r_active[0];
  assign w_spawn_sel[1] = w_spawn & r_active[0] & ~r_active[1];

  assign shots_fired = r_shots;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shoot_d  <= 1'b0;
      r_fire_req <= 1'b0;
      r_cooldown <= '0;
      r_shots    <= 8'd0;
    end else begin
      r_shoot_d <= shoot;
      if (move)
        r_fire_req <= 1'b0;
      else if (w_edge)
        r_fire_req <= 1'b1;
      if (w_spawn) begin
        r_cooldown <= CD_W'(COOLDOWN);
        r_shots    <= r_shots + 8'd1;
      end else if (move && (r_cooldown != '0)) begin
        r_cooldown <= r_cooldown - 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [10:0] w_h;
      logic [10:0] w_v;
      logic [10:0] w_x_lo;
      logic [10:0] w_y_lo;
      logic        w_cover;

      assign w_h     = {1'b0, hcount};
      assign w_v     = {1'b0, vcount};
      assign w_x_lo  = {1'b0, r_x[gi]};
      assign w_y_lo  = {1'b0, r_y[gi]};
      assign w_cover = r_active[gi] & ~r_hit_pend[gi]
                     & (w_h >= w_x_lo) & (w_h < w_x_lo + 11'(BULLET_W))
                     & (w_v >= w_y_lo) & (w_v < w_y_lo + 11'(BULLET_H));

      assign bullet_active[gi] = r_active[gi];
      assign draw_bullets[gi]  = r_draw[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_active[gi]   <= 1'b0;
          r_hit_pend[gi] <= 1'b0;
          r_draw[gi]     <= 1'b0;
          r_x[gi]        <= 10'd0;
          r_y[gi]        <= 10'd0;
        end else begin
          if (pixpulse)
            r_draw[gi] <= w_cover;
          if (move) begin
            r_hit_pend[gi] <= 1'b0;
            if (w_spawn_sel[gi]) begin
              r_active[gi] <= 1'b1;
              r_x[gi]      <= ship_x;
              r_y[gi]      <= ship_y - 10'(BULLET_H);
            end else if (r_active[gi]) begin
              if (r_hit_pend[gi] || (r_y[gi] <= 10'(SPEED)))
                r_active[gi] <= 1'b0;
              else
                r_y[gi] <= r_y[gi] - 10'(SPEED);
            end
          end else if (hit[gi] && r_active[gi]) begin
            r_hit_pend[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule
